// File: rtl/ifetch_unit_if.sv
// Fetch-stage bundle: instruction-memory req/ack, IR/PC toward decode, commit/NPC inputs from the datapath.
// master = ifetch_unit side, slave = memory/datapath/bench side.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic        commit;
  logic [1:0]  NPCOp;
  logic [31:0] rs_data;
  logic [31:0] retired;
  logic        misalign;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, PC, retired, misalign,
    input  imem_ack, imem_rdata, commit, NPCOp, rs_data
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, PC, retired, misalign,
    output imem_ack, imem_rdata, commit, NPCOp, rs_data
  );
endinterface

// File: rtl/ifetch_unit.sv
// MIPS fetch stage: PC + IR, one instruction in flight; valid N+1 cycles after FETCH entry for N wait states.
// Backpressure: memory stalls via imem_ack, the datapath holds IR by withholding commit.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rstn,
  ifetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retired;
  logic        r_misalign;
  logic        w_req;
  logic        w_valid;
  logic        w_load_ir;
  logic        w_retire;
  logic        w_jr_misalign;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_npc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_RST;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RST:   w_next_state = ST_FETCH;
      ST_FETCH: if (bus.imem_ack) w_next_state = ST_HOLD;
      ST_HOLD:  if (bus.commit)   w_next_state = ST_FETCH;
      default:  w_next_state = ST_RST;
    endcase
  end

  // Outputs are pure state decodes so req/valid never see a combinational input path.
  always_comb begin
    w_req   = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      ST_FETCH: w_req   = 1'b1;
      ST_HOLD:  w_valid = 1'b1;
      default: begin
        w_req   = 1'b0;
        w_valid = 1'b0;
      end
    endcase
  end

  assign w_load_ir     = (r_state == ST_FETCH) && bus.imem_ack;
  assign w_retire      = (r_state == ST_HOLD) && bus.commit;
  assign w_jr_misalign = (bus.NPCOp == 2'b11) && (bus.rs_data[1:0] != 2'b00);

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  always_comb begin
    w_npc = w_pc_plus4;
    case (bus.NPCOp)
      NPC_PLUS4:  w_npc = w_pc_plus4;
      NPC_BRANCH: w_npc = w_pc_plus4 + w_br_off;
      NPC_JUMP:   w_npc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
      default:    w_npc = {bus.rs_data[31:2], 2'b00};
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0;
      r_retired  <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      if (w_load_ir) r_instr <= bus.imem_rdata;
      if (w_retire) begin
        r_pc      <= w_npc;
        r_retired <= r_retired + 32'd1;
        if (w_jr_misalign) r_misalign <= 1'b1;
      end
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = w_valid;
  assign bus.PC          = r_pc;
  assign bus.retired     = r_retired;
  assign bus.misalign    = r_misalign;

endmodule
